avg_uart_tx: RTL and testbench

- Downstream consumer of the 8-bit moving-average stage.
- Decimates the signed average output at a fixed sample rate and buffers samples in a small FIFO.
- Serialises each sample as an 8N1 UART frame on a single `tx` line for off-chip logging.
- Sits directly after the moving-average top-level entity, on the same clock/reset domain.

---
 rtl/avg_uart_tx.sv | 153 +++++++++++++++
 tb/tb_avg_uart_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/avg_uart_tx.sv
// Decimates the signed moving-average output, queues samples in a small FIFO
// and sends each one as an 8N1 UART frame on tx (LSB first, idle high).
module avg_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SAMPLE_DIV   = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       system1000,
  input  logic       system1000_rstn,
  input  logic [7:0] avg_in,
  output logic       tx,
  output logic       busy,
  output logic       fifo_overflow
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DW-1:0] div_cnt;
  logic          strobe;
  logic          push;
  logic          pop;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  state_t        state,   state_n;
  logic [BW-1:0] baud,    baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift,   shift_n;
  logic          tx_n;
  logic          busy_n;

  assign strobe = (div_cnt == DIV_LAST);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push   = strobe && ((count != DEPTH_C) || pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      div_cnt <= '0;
    end else if (strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // NOTE: sample storage is left unreset; count==0 already marks every entry invalid.
  always_ff @(posedge system1000) begin
    if (push) mem[wr_ptr] <= avg_in;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (strobe && !push) fifo_overflow <= 1'b1;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
      busy    <= busy_n;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    baud_n  = baud + 1'b1;
    bit_n   = bit_cnt;
    shift_n = shift;
    tx_n    = tx;
    busy_n  = busy;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = shift >> 1;
            tx_n    = shift[1];
          end
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          state_n = IDLE;
          baud_n  = '0;
          busy_n  = 1'b0;
          tx_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avg_uart_tx.sv
// Bench for avg_uart_tx: three configurations share clock and reset, each
// compared every cycle against a frame-timing model plus hand-derived points.
module tb_avg_uart_tx;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] avg     [3];
  logic       tx_v    [3];
  logic       busy_v  [3];
  logic       ovf_v   [3];
  logic       cmp_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  avg_uart_tx #(.CLKS_PER_BIT(4), .SAMPLE_DIV(64), .FIFO_DEPTH(4)) u0 (
    .system1000(clk), .system1000_rstn(rstn), .avg_in(avg[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .fifo_overflow(ovf_v[0]));
  avg_uart_tx #(.CLKS_PER_BIT(4), .SAMPLE_DIV(8), .FIFO_DEPTH(4)) u1 (
    .system1000(clk), .system1000_rstn(rstn), .avg_in(avg[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .fifo_overflow(ovf_v[1]));
  avg_uart_tx #(.CLKS_PER_BIT(2), .SAMPLE_DIV(1), .FIFO_DEPTH(4)) u2 (
    .system1000(clk), .system1000_rstn(rstn), .avg_in(avg[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .fifo_overflow(ovf_v[2]));

  function automatic int cpb_of(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 64 : (i == 1) ? 8 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending samples and the start edge of the frame in flight;
  // the line level follows from which tenth of the frame the current edge falls in.
  int         m_q   [3][8];
  int         m_qn  [3];
  int         m_k   [3];
  bit         m_act [3];
  int         m_s   [3];
  logic [7:0] m_fb  [3];
  logic       m_ovf [3];
  logic       m_tx  [3];
  logic       m_busy[3];

  initial begin : model
    int  cpb, idx;
    bit  do_pop;
    forever begin
      @(posedge clk or negedge rstn);
      for (int i = 0; i < 3; i++) begin
        if (!rstn) begin
          m_qn[i] = 0; m_k[i] = 0; m_act[i] = 1'b0; m_s[i] = 0;
          m_fb[i] = 8'h00; m_ovf[i] = 1'b0; m_tx[i] = 1'b1; m_busy[i] = 1'b0;
        end else begin
          cpb    = cpb_of(i);
          do_pop = (m_qn[i] > 0) && (!m_act[i] || m_k[i] >= m_s[i] + 10 * cpb + 1);
          if (do_pop) begin
            m_fb[i] = 8'(m_q[i][0]);
            for (int j = 0; j < 7; j++) m_q[i][j] = m_q[i][j+1];
            m_qn[i]--;
            m_act[i] = 1'b1;
            m_s[i]   = m_k[i];
          end
          if ((m_k[i] % div_of(i)) == div_of(i) - 1) begin
            if (m_qn[i] < 4) begin
              m_q[i][m_qn[i]] = int'(avg[i]);
              m_qn[i]++;
            end else begin
              m_ovf[i] = 1'b1;
            end
          end
          if (m_act[i] && (m_k[i] - m_s[i]) < 10 * cpb) begin
            idx       = (m_k[i] - m_s[i]) / cpb;
            m_tx[i]   = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : m_fb[i][idx-1];
            m_busy[i] = 1'b1;
          end else begin
            m_tx[i]   = 1'b1;
            m_busy[i] = 1'b0;
          end
          m_k[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("tx%0d", i),   32'(tx_v[i]),   32'(m_tx[i]));
        check($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(m_busy[i]));
        check($sformatf("ovf%0d", i),  32'(ovf_v[i]),  32'(m_ovf[i]));
      end
    end
  end

  task automatic drive(input int e);
    avg[0] = (e < 64) ? 8'h5A : (e < 128) ? 8'hFF : (e < 192) ? 8'h80 : 8'hA5;
    avg[1] = 8'(e / 8 + 1);
    avg[2] = 8'(e);
  endtask

  logic [9:0] pat_5a;
  int         busy_hi;

  initial begin
    pat_5a  = 10'b1010110100;
    busy_hi = 0;
    drive(0);
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_tx",   32'(tx_v[0]),   32'd1);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_ovf",  32'(ovf_v[1]),  32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int e = 0; e <= 273; e++) begin
      @(posedge clk);
      #1;
      if (e == 63) begin
        check("pre_frame_tx",   32'(tx_v[0]),   32'd1);
        check("pre_frame_busy", 32'(busy_v[0]), 32'd0);
      end
      if (e >= 65 && e <= 101 && (e - 65) % 4 == 0)
        check($sformatf("f5a_bit%0d", (e - 65) / 4), 32'(tx_v[0]), 32'(pat_5a[(e - 65) / 4]));
      if (e <= 127 && busy_v[0]) busy_hi++;
      if (e == 127) begin
        check("busy_len", 32'(busy_hi), 32'd40);
        check("gap_tx",   32'(tx_v[0]), 32'd1);
      end
      if (e == 128) check("fff_start", 32'(tx_v[0]), 32'd0);
      if (e >= 133 && e <= 161 && (e - 133) % 4 == 0)
        check($sformatf("fff_bit%0d", (e - 133) / 4), 32'(tx_v[0]), 32'd1);
      if (e >= 197 && e <= 225 && (e - 197) % 4 == 0)
        check($sformatf("f80_bit%0d", (e - 197) / 4), 32'(tx_v[0]), (e == 225) ? 32'd1 : 32'd0);
      if (e == 13) check("u1_f1_bit0", 32'(tx_v[1]), 32'd1);
      if (e == 17) check("u1_f1_bit1", 32'(tx_v[1]), 32'd0);
      if (e == 46) check("u1_ovf_before", 32'(ovf_v[1]), 32'd0);
      if (e == 47) check("u1_ovf_at47",   32'(ovf_v[1]), 32'd1);
      if (e == 4)  check("u2_ovf_before", 32'(ovf_v[2]), 32'd0);
      if (e == 5)  check("u2_ovf_at5",    32'(ovf_v[2]), 32'd1);
      if (e == 273) begin
        check("mid_bit3_tx",   32'(tx_v[0]),   32'd0);
        check("mid_bit3_busy", 32'(busy_v[0]), 32'd1);
        check("u0_ovf_clear",  32'(ovf_v[0]),  32'd0);
        check("u1_ovf_set",    32'(ovf_v[1]),  32'd1);
      end
      drive(e + 1);
    end

    #1 rstn = 1'b0;
    #1;
    check("async_tx",   32'(tx_v[0]),   32'd1);
    check("async_busy", 32'(busy_v[0]), 32'd0);
    check("async_ovf1", 32'(ovf_v[1]),  32'd0);
    check("async_ovf2", 32'(ovf_v[2]),  32'd0);
    repeat (3) @(negedge clk);
    drive(0);
    rstn = 1'b1;

    for (int e = 0; e <= 70; e++) begin
      @(posedge clk);
      #1;
      if (e == 63) begin
        check("rel_idle_tx",   32'(tx_v[0]),   32'd1);
        check("rel_idle_busy", 32'(busy_v[0]), 32'd0);
      end
      if (e == 64) begin
        check("rel_start_tx",   32'(tx_v[0]),   32'd0);
        check("rel_start_busy", 32'(busy_v[0]), 32'd1);
      end
      drive(e + 1);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
